// File: rtl/ntt_agu_pkg.sv
// Shared NTT address-generation types: bank request bundle, bank parity, FIFO sizing.
// Shared with the read scheduler; D_W fixes the order/l width of bank_req_t.
package ntt_agu_pkg;

    localparam int D_W            = 8;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int FIFO_AW        = $clog2(FIFO_DEPTH_DEF);

    typedef struct packed {
        logic           swap;
        logic [D_W-2:0] addr_b0;
        logic [D_W-2:0] addr_b1;
        logic [D_W-1:0] l;
    } bank_req_t;

    function automatic logic bank_parity(input logic [D_W-1:0] x);
        return ^x;
    endfunction

endpackage

// File: rtl/ntt_sync_fifo.sv
// Small synchronous FIFO, sync active-high reset, storage-driven read data.
// DEPTH must be a power of two so the pointers wrap on their own.
module ntt_sync_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  T     din,
    output T     dout,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    T             mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ntt_bank_addr_map.sv
// Maps butterfly operand pairs onto two parity-selected banks and buffers them.
// Optional macro NTT_BANK_CONFLICT_CHK_EN enables the sticky same-bank check.
module ntt_bank_addr_map
    import ntt_agu_pkg::*;
#(
    parameter int D_WIDTH    = D_W,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [D_WIDTH-1:0] in_order_0,
    input  logic [D_WIDTH-1:0] in_order_1,
    input  logic [D_WIDTH-1:0] in_l,
    input  logic               in_done,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_swap,
    output logic [D_WIDTH-2:0] out_addr_b0,
    output logic [D_WIDTH-2:0] out_addr_b1,
    output logic [D_WIDTH-1:0] out_l,
    output logic               out_done,
    output logic               overflow,
    output logic               conflict_err
);

    bank_req_t map_req;
    bank_req_t s1_req;
    bank_req_t head;
    logic      s1_valid;
    logic      full;
    logic      empty;
    logic      push;
    logic      pop;
    logic      done_pend;
    logic      done_fire;
    logic      overflow_q;

    always_comb begin
        map_req         = '0;
        map_req.swap    = bank_parity(in_order_0);
        map_req.addr_b0 = map_req.swap ? in_order_1[D_WIDTH-1:1]
                                       : in_order_0[D_WIDTH-1:1];
        map_req.addr_b1 = map_req.swap ? in_order_0[D_WIDTH-1:1]
                                       : in_order_1[D_WIDTH-1:1];
        map_req.l       = in_l;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_req   <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) s1_req <= map_req;
        end
    end

    assign pop       = out_valid && out_ready;
    assign push      = s1_valid && (!full || pop);
    assign out_valid = !empty;
    assign in_ready  = !full || pop;

    ntt_sync_fifo #(
        .T     (bank_req_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (s1_req),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign out_swap    = head.swap;
    assign out_addr_b0 = head.addr_b0;
    assign out_addr_b1 = head.addr_b1;
    assign out_l       = head.l;

    // Done waits until nothing is left in S1 or the FIFO.
    assign done_fire = done_pend && !s1_valid && empty;
    assign out_done  = done_fire;
    assign overflow  = overflow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            done_pend  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            done_pend  <= in_done || (done_pend && !done_fire);
            overflow_q <= overflow_q || (s1_valid && full && !pop);
        end
    end

`ifdef NTT_BANK_CONFLICT_CHK_EN
    logic s1_conf;
    logic conf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_conf <= 1'b0;
            conf_q  <= 1'b0;
        end else begin
            s1_conf <= in_valid &&
                       (bank_parity(in_order_0) == bank_parity(in_order_1));
            conf_q  <= conf_q || (s1_valid && s1_conf);
        end
    end

    assign conflict_err = conf_q;
`else
    assign conflict_err = 1'b0;
`endif

endmodule

// File: tb/tb_ntt_bank_addr_map.sv
// Directed self-checking bench for ntt_bank_addr_map.
// Inputs change 1 ns after the rising edge; outputs are checked there too.
module tb_ntt_bank_addr_map;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_order_0;
    logic [7:0] in_order_1;
    logic [7:0] in_l;
    logic       in_done;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic       out_swap;
    logic [6:0] out_addr_b0;
    logic [6:0] out_addr_b1;
    logic [7:0] out_l;
    logic       out_done;
    logic       overflow;
    logic       conflict_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ntt_bank_addr_map dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_order_0   (in_order_0),
        .in_order_1   (in_order_1),
        .in_l         (in_l),
        .in_done      (in_done),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_swap     (out_swap),
        .out_addr_b0  (out_addr_b0),
        .out_addr_b1  (out_addr_b1),
        .out_l        (out_l),
        .out_done     (out_done),
        .overflow     (overflow),
        .conflict_err (conflict_err)
    );

    function automatic logic par(input logic [7:0] x);
        logic p;
        p = 1'b0;
        for (int i = 0; i < 8; i++) p = p ^ x[i];
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] o0,
                         input logic [7:0] o1, input logic [7:0] l);
        in_valid   = v;
        in_order_0 = o0;
        in_order_1 = o1;
        in_l       = l;
    endtask

    task automatic chk_head(input string tag, input logic [7:0] o0,
                            input logic [7:0] o1, input logic [7:0] l);
        logic s;
        s = par(o0);
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_swap"}, out_swap, s);
        chk({tag, "_b0"}, out_addr_b0, s ? 7'(o1 >> 1) : 7'(o0 >> 1));
        chk({tag, "_b1"}, out_addr_b1, s ? 7'(o0 >> 1) : 7'(o1 >> 1));
        chk({tag, "_l"}, out_l, l);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 8'd0, 8'd0, 8'd0);
        in_done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        out_ready = 1'b1;
        do_reset();

        chk("rst_valid", out_valid, 1'b0);
        chk("rst_ready", in_ready, 1'b1);
        chk("rst_swap", out_swap, 1'b0);
        chk("rst_b0", out_addr_b0, 7'd0);
        chk("rst_b1", out_addr_b1, 7'd0);
        chk("rst_l", out_l, 8'd0);
        chk("rst_done", out_done, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_conf", conflict_err, 1'b0);

        // 8/9 l=3: two-edge latency, swap=1, both locals 4
        drive(1'b1, 8'd8, 8'd9, 8'd3);
        tick();
        drive(1'b1, 8'd12, 8'd13, 8'd5);
        chk("a_lat", out_valid, 1'b0);
        tick();
        drive(1'b0, 8'd0, 8'd0, 8'd0);
        chk("a_valid", out_valid, 1'b1);
        chk("a_swap", out_swap, 1'b1);
        chk("a_b0", out_addr_b0, 7'd4);
        chk("a_b1", out_addr_b1, 7'd4);
        chk("a_l", out_l, 8'd3);
        tick();
        chk("b_valid", out_valid, 1'b1);
        chk("b_swap", out_swap, 1'b0);
        chk("b_b0", out_addr_b0, 7'd6);
        chk("b_b1", out_addr_b1, 7'd6);
        chk("b_l", out_l, 8'd5);
        tick();
        chk("b_empty", out_valid, 1'b0);

        // 8 back-to-back pairs stream with no bubble
        for (int t = 0; t < 10; t++) begin
            if (t < 8) drive(1'b1, 8'(t * 6 + 3), 8'(t * 6 + 4), 8'(t));
            else       drive(1'b0, 8'd0, 8'd0, 8'd0);
            tick();
            if (t >= 1 && t <= 8)
                chk_head($sformatf("s%0d", t - 1), 8'((t - 1) * 6 + 3),
                         8'((t - 1) * 6 + 4), 8'(t - 1));
        end
        chk("s_end", out_valid, 1'b0);

        // 6 pairs against a stalled consumer: 4 held, 2 dropped
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 8'(20 + 2 * k), 8'(41 + 2 * k), 8'(k + 1));
            tick();
        end
        drive(1'b0, 8'd0, 8'd0, 8'd0);
        tick();
        tick();
        chk("f_ready", in_ready, 1'b0);
        chk("f_ovf", overflow, 1'b1);
        chk_head("f_h0", 8'd20, 8'd41, 8'd1);
        out_ready = 1'b1;
        #1;
        chk("f_ready_pop", in_ready, 1'b1);
        tick();
        chk_head("f_h1", 8'd22, 8'd43, 8'd2);
        chk("f_ovf_sticky", overflow, 1'b1);

        // reset mid-stream with a pair arriving
        rst = 1'b1;
        drive(1'b1, 8'd7, 8'd6, 8'd9);
        tick();
        chk("mr_valid", out_valid, 1'b0);
        chk("mr_ready", in_ready, 1'b1);
        chk("mr_ovf", overflow, 1'b0);
        chk("mr_swap", out_swap, 1'b0);
        chk("mr_b0", out_addr_b0, 7'd0);
        chk("mr_b1", out_addr_b1, 7'd0);
        chk("mr_l", out_l, 8'd0);
        chk("mr_done", out_done, 1'b0);
        rst = 1'b0;
        drive(1'b0, 8'd0, 8'd0, 8'd0);
        tick();
        tick();
        chk("mr_discard", out_valid, 1'b0);

        // full FIFO with simultaneous push and pop
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 8'(50 + k), 8'(70 + k), 8'(10 + k));
            tick();
        end
        drive(1'b0, 8'd0, 8'd0, 8'd0);
        tick();
        chk("pp_full", in_ready, 1'b0);
        drive(1'b1, 8'd54, 8'd74, 8'd14);
        tick();
        drive(1'b0, 8'd0, 8'd0, 8'd0);
        out_ready = 1'b1;
        #1;
        chk("pp_ready", in_ready, 1'b1);
        tick();
        out_ready = 1'b0;
        #1;
        chk("pp_still_full", in_ready, 1'b0);
        chk("pp_no_ovf", overflow, 1'b0);
        out_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            chk_head($sformatf("pp%0d", k), 8'(50 + k), 8'(70 + k), 8'(10 + k));
            tick();
        end
        chk("pp_empty", out_valid, 1'b0);

        // done arriving with the last of 3 queued entries
        do_reset();
        out_ready = 1'b0;
        drive(1'b1, 8'd1, 8'd2, 8'd0);
        tick();
        drive(1'b1, 8'd3, 8'd4, 8'd0);
        tick();
        drive(1'b1, 8'd5, 8'd6, 8'd0);
        in_done = 1'b1;
        tick();
        drive(1'b0, 8'd0, 8'd0, 8'd0);
        in_done = 1'b0;
        tick();
        chk("d_wait", out_done, 1'b0);
        out_ready = 1'b1;
        tick();
        chk("d_pop1", out_done, 1'b0);
        tick();
        chk("d_pop2", out_done, 1'b0);
        tick();
        chk("d_pulse", out_done, 1'b1);
        tick();
        chk("d_once", out_done, 1'b0);

        // done on empty pipeline
        in_done = 1'b1;
        tick();
        in_done = 1'b0;
        chk("de_pulse", out_done, 1'b1);
        tick();
        chk("de_once", out_done, 1'b0);

        // two dones while pending merge into one pulse
        drive(1'b1, 8'd9, 8'd10, 8'd2);
        in_done = 1'b1;
        tick();
        drive(1'b0, 8'd0, 8'd0, 8'd0);
        chk("dm_blk1", out_done, 1'b0);
        tick();
        in_done = 1'b0;
        chk("dm_blk2", out_done, 1'b0);
        tick();
        chk("dm_pulse", out_done, 1'b1);
        tick();
        chk("dm_once", out_done, 1'b0);

        // 3/5 share bank 0
        drive(1'b1, 8'd3, 8'd5, 8'd1);
        tick();
        drive(1'b1, 8'd8, 8'd9, 8'd1);
        tick();
        drive(1'b0, 8'd0, 8'd0, 8'd0);
        chk_head("c_head", 8'd3, 8'd5, 8'd1);
`ifdef NTT_BANK_CONFLICT_CHK_EN
        chk("c_set", conflict_err, 1'b1);
        tick();
        tick();
        chk("c_sticky", conflict_err, 1'b1);
`else
        chk("c_tied", conflict_err, 1'b0);
        tick();
        tick();
        chk("c_tied2", conflict_err, 1'b0);
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("c_rst", conflict_err, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
